// File: rtl/regfile_param_if.sv
// regfile_param_if: decode/writeback side bundle of the register file.
// master drives addresses/data/control; slave returns read data and status.
interface regfile_param_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          start;
  logic          wrt_en;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;
  logic [DW-1:0] wrt;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          busy;
  logic          ready;

  modport master (
    output start, wrt_en, a1, a2, a3, wrt,
    input  rd1, rd2, busy, ready
  );

  modport slave (
    input  start, wrt_en, a1, a2, a3, wrt,
    output rd1, rd2, busy, ready
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R1W register file with post-reset clear.
// Optional REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] mem [DEPTH];

  logic          we;
  logic [IW-1:0] wa;
  logic [DW-1:0] wd;
  logic          live, ok1, ok2;

  function automatic logic ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) &&
           !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // single write port shared by the clear sequencer and RUN writes
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    wa        = clr_cnt_q[IW-1:0];
    wd        = '0;
    unique case (state_q)
      CLEAR: begin
        we        = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.wrt_en && ok(bus.a3)) begin
          we = 1'b1;
          wa = bus.a3[IW-1:0];
          wd = bus.wrt;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // no reset on the array so it can map onto RAM
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= wd;
  end

  assign live = (state_q != CLEAR);
  assign ok1  = ok(bus.a1);
  assign ok2  = ok(bus.a2);

  always_comb begin
    bus.rd1 = (live && ok1) ? mem[bus.a1[IW-1:0]] : '0;
    bus.rd2 = (live && ok2) ? mem[bus.a2[IW-1:0]] : '0;
`ifdef REGFILE_BYPASS_EN
    if (state_q == RUN && bus.wrt_en) begin
      if (ok1 && bus.a1 == bus.a3) bus.rd1 = bus.wrt;
      if (ok2 && bus.a2 == bus.a3) bus.rd2 = bus.wrt;
    end
`endif
  end

  assign bus.busy  = (state_q == CLEAR);
  assign bus.ready = (state_q == RUN);
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: random + directed checks of two regfile_param builds
// (DEPTH=32 with zero reg, DEPTH=24 without) against an array model.
module tb_regfile_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DA = 32;
  localparam int DB = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          wrt_en = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;
  logic [AW-1:0] a3 = '0;
  logic [DW-1:0] wrt = '0;

  regfile_param_if #(.DW(DW), .AW(AW)) ia ();
  regfile_param_if #(.DW(DW), .AW(AW)) ib ();

  assign ia.start  = start;
  assign ia.wrt_en = wrt_en;
  assign ia.a1     = a1;
  assign ia.a2     = a2;
  assign ia.a3     = a3;
  assign ia.wrt    = wrt;
  assign ib.start  = start;
  assign ib.wrt_en = wrt_en;
  assign ib.a1     = a1;
  assign ib.a2     = a2;
  assign ib.a3     = a3;
  assign ib.wrt    = wrt;

  regfile_param #(.DW(DW), .DEPTH(DA), .AW(AW), .ZERO_REG(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  regfile_param #(.DW(DW), .DEPTH(DB), .AW(AW), .ZERO_REG(0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: phase 0=clear 1=idle 2=run
  logic [DW-1:0] ma [DA];
  logic [DW-1:0] mb [DB];
  int ph_a = 0, ph_b = 0;
  int left_a = DA, left_b = DB;
  int busy_a_s, busy_b_s;
  bit bypass;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(bit b, logic [AW-1:0] a);
    int d  = b ? DB : DA;
    bit z  = !b;
    int ph = b ? ph_b : ph_a;
    if (ph == 0 || int'(a) >= d || (z && a == 0)) return '0;
    if (bypass && ph == 2 && wrt_en && a == a3) return wrt;
    return b ? mb[a] : ma[a];
  endfunction

  function automatic bit wr_ok(bit b);
    int d = b ? DB : DA;
    return int'(a3) < d && !(!b && a3 == 0);
  endfunction

  task automatic cycle();
    @(negedge clk);
    chk("a_rd1", ia.rd1, exp_rd(0, a1));
    chk("a_rd2", ia.rd2, exp_rd(0, a2));
    chk("b_rd1", ib.rd1, exp_rd(1, a1));
    chk("b_rd2", ib.rd2, exp_rd(1, a2));
    chk("a_busy", DW'(ia.busy), DW'(ph_a == 0));
    chk("a_ready", DW'(ia.ready), DW'(ph_a == 2));
    chk("b_busy", DW'(ib.busy), DW'(ph_b == 0));
    chk("b_ready", DW'(ib.ready), DW'(ph_b == 2));
    busy_a_s = int'(ia.busy);
    busy_b_s = int'(ib.busy);
    @(posedge clk);
    if (rst) begin
      ph_a = 0; left_a = DA; foreach (ma[i]) ma[i] = '0;
      ph_b = 0; left_b = DB; foreach (mb[i]) mb[i] = '0;
    end else begin
      case (ph_a)
        0: begin left_a--; if (left_a == 0) ph_a = 1; end
        1: if (start) ph_a = 2;
        default: if (wrt_en && wr_ok(0)) ma[a3] = wrt;
      endcase
      case (ph_b)
        0: begin left_b--; if (left_b == 0) ph_b = 1; end
        1: if (start) ph_b = 2;
        default: if (wrt_en && wr_ok(1)) mb[a3] = wrt;
      endcase
    end
    #1;
  endtask

  initial begin
    int nb_a, nb_b;
`ifdef REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    nb_a = 0; nb_b = 0;
    repeat (40) begin
      a1 = AW'($urandom_range(31, 0));
      a2 = AW'($urandom_range(31, 0));
      cycle();
      nb_a += busy_a_s;
      nb_b += busy_b_s;
    end
    chk("clr_len_a", DW'(nb_a), DW'(DA));
    chk("clr_len_b", DW'(nb_b), DW'(DB));
    chk("idle_ready", DW'(ia.ready), '0);

    for (int i = 0; i < 32; i++) begin
      a1 = AW'(i); a2 = AW'(31 - i);
      cycle();
    end

    wrt_en = 1'b1; a3 = 6; wrt = 50; a1 = 6;
    cycle();
    wrt_en = 1'b0;
    #1 chk("idle_wr", ia.rd1, '0);

    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run_ready", DW'(ia.ready), 1);

    wrt_en = 1'b1; a3 = 6; wrt = 50;
    cycle();
    a3 = 5; wrt = 2;
    cycle();
    wrt_en = 1'b0; a1 = 6; a2 = 5;
    #1;
    chk("dual_rd1", ia.rd1, 50);
    chk("dual_rd2", ia.rd2, 2);
    chk("dual_b", ib.rd2, 2);
    a2 = 6;
    #1;
    chk("same_rd1", ia.rd1, 50);
    chk("same_rd2", ia.rd2, 50);

    wrt_en = 1'b1; a3 = 0; wrt = 7;
    cycle();
    wrt_en = 1'b0; a1 = 0;
    #1;
    chk("zero_a", ia.rd1, '0);
    chk("zero_off_b", ib.rd1, 7);

    wrt_en = 1'b1; a3 = 30; wrt = 9;
    cycle();
    wrt_en = 1'b0; a1 = 30;
    #1;
    chk("oor_b", ib.rd1, '0);
    chk("inr_a", ia.rd1, 9);
    for (int i = 0; i < DB; i++) begin
      a1 = AW'(i);
      cycle();
    end

    wrt_en = 1'b1; a1 = 4; a3 = 4; wrt = 7;
    #1 chk("rdw_pre", ia.rd1, bypass ? DW'(7) : DW'(0));
    cycle();
    wrt_en = 1'b0;
    #1 chk("rdw_post", ia.rd1, 7);

    repeat (400) begin
      wrt_en = 1'($urandom_range(1, 0));
      start  = 1'($urandom_range(1, 0));
      a1  = AW'($urandom_range(31, 0));
      a2  = AW'($urandom_range(31, 0));
      a3  = ($urandom_range(3, 0) == 0) ? a1 : AW'($urandom_range(31, 0));
      wrt = $urandom;
      cycle();
    end
    start = 1'b0;

    wrt_en = 1'b1; a3 = 9; wrt = 9;
    cycle();
    wrt_en = 1'b0; a1 = 9;
    #1 chk("pre_rst", ia.rd1, 9);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_busy", DW'(ia.busy), 1);
    chk("rst_rd1", ia.rd1, '0);
    repeat (DA) cycle();
    chk("rst_done", DW'(ia.busy), '0);
    chk("rst_clr9", ia.rd1, '0);

    wrt_en = 1'b1; a3 = 9; wrt = 9;
    cycle();
    wrt_en = 1'b0;
    #1 chk("rst_idle_wr", ia.rd1, '0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wrt_en = 1'b1;
    cycle();
    wrt_en = 1'b0;
    #1 chk("rst_run_wr", ia.rd1, 9);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
